// File: rtl/c1581_sd_arb.sv
// Round-robin arbiter that funnels up to four drive sector requests onto the
// single host block-device port and routes the host acknowledge/data back.
module c1581_sd_arb #(
    parameter int unsigned NDR = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [31:0]          drv_lba      [NDR],
    input  logic [NDR-1:0]       drv_rd,
    input  logic [NDR-1:0]       drv_wr,
    output logic [NDR-1:0]       drv_ack,
    input  logic [7:0]           drv_buff_din [NDR],
    output logic [31:0]          host_lba,
    output logic                 host_rd,
    output logic                 host_wr,
    input  logic                 host_ack,
    output logic [7:0]           host_buff_din,
    output logic [1:0]           sel,
    output logic                 busy
);

    localparam int unsigned LBA_W = 32;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned MAX_D = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [LBA_W-1:0]   host_lba_q, host_lba_d;
    logic               host_rd_q, host_rd_d;
    logic               host_wr_q, host_wr_d;
    logic               busy_q, busy_d;

    // Ports padded out to the maximum drive count; absent drives never request.
    logic [MAX_D-1:0]   req4;
    logic [MAX_D-1:0]   wr4;
    logic [LBA_W-1:0]   lba4 [MAX_D];
    logic [DAT_W-1:0]   din4 [MAX_D];

    for (genvar g = 0; g < MAX_D; g++) begin : g_pad
        if (g < NDR) begin : g_real
            assign req4[g] = drv_rd[g] | drv_wr[g];
            assign wr4[g]  = drv_wr[g];
            assign lba4[g] = drv_lba[g];
            assign din4[g] = drv_buff_din[g];
        end else begin : g_none
            assign req4[g] = 1'b0;
            assign wr4[g]  = 1'b0;
            assign lba4[g] = '0;
            assign din4[g] = '0;
        end
    end

    // Round-robin search starting one past the last granted drive.
    logic               found_c;
    logic [SEL_W-1:0]   grant_c;
    logic [SEL_W-1:0]   cand_c;

    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        cand_c  = '0;
        for (int unsigned o = 1; o <= NDR; o++) begin
            cand_c = SEL_W'((32'(last_q) + o) % NDR);
            if (!found_c && req4[cand_c]) begin
                found_c = 1'b1;
                grant_c = cand_c;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            last_q     <= SEL_W'(NDR - 1);
            host_lba_q <= '0;
            host_rd_q  <= 1'b0;
            host_wr_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            host_lba_q <= host_lba_d;
            host_rd_q  <= host_rd_d;
            host_wr_q  <= host_wr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        host_lba_d = host_lba_q;
        host_rd_d  = host_rd_q;
        host_wr_d  = host_wr_q;

        unique case (state_q)
            ST_IDLE: begin
                // A stray acknowledge must finish before any new grant.
                if (host_ack) begin
                    state_d = ST_DRAIN;
                end else if (found_c) begin
                    state_d    = ST_REQ;
                    sel_d      = grant_c;
                    last_d     = grant_c;
                    host_lba_d = lba4[grant_c];
                    host_wr_d  = wr4[grant_c];
                    host_rd_d  = !wr4[grant_c];
                end
            end
            ST_REQ: begin
                if (host_ack) begin
                    state_d   = ST_XFER;
                    host_rd_d = 1'b0;
                    host_wr_d = 1'b0;
                end else if (!req4[sel_q]) begin
                    state_d   = ST_IDLE;
                    host_rd_d = 1'b0;
                    host_wr_d = 1'b0;
                end
            end
            ST_XFER: begin
                if (!host_ack) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!host_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Acknowledge routing is combinational so the drive sees host_ack with no delay.
    logic ack_route_c;
    assign ack_route_c = host_ack && ((state_q == ST_REQ) || (state_q == ST_XFER));

    for (genvar g = 0; g < NDR; g++) begin : g_ack
        assign drv_ack[g] = ack_route_c && (sel_q == SEL_W'(g));
    end

    assign host_buff_din = din4[sel_q];
    assign host_lba      = host_lba_q;
    assign host_rd       = host_rd_q;
    assign host_wr       = host_wr_q;
    assign sel           = sel_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_c1581_sd_arb.sv
// Directed bench for c1581_sd_arb with four drive ports.
module tb_c1581_sd_arb;

    localparam int unsigned NDR = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [31:0]     drv_lba      [NDR];
    logic [NDR-1:0]  drv_rd;
    logic [NDR-1:0]  drv_wr;
    logic [NDR-1:0]  drv_ack;
    logic [7:0]      drv_buff_din [NDR];
    logic [31:0]     host_lba;
    logic            host_rd;
    logic            host_wr;
    logic            host_ack;
    logic [7:0]      host_buff_din;
    logic [1:0]      sel;
    logic            busy;

    int checks = 0;
    int errors = 0;

    c1581_sd_arb #(.NDR(NDR)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .drv_lba       (drv_lba),
        .drv_rd        (drv_rd),
        .drv_wr        (drv_wr),
        .drv_ack       (drv_ack),
        .drv_buff_din  (drv_buff_din),
        .host_lba      (host_lba),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .sel           (sel),
        .busy          (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full grant/ack cycle for a drive expected to win the next search.
    task automatic serve(input logic [1:0] exp_sel, input logic [31:0] exp_lba, input logic exp_wr);
        tick();
        chk("grant_sel", 32'(sel), 32'(exp_sel));
        chk("grant_lba", host_lba, exp_lba);
        chk("grant_wr", 32'(host_wr), 32'(exp_wr));
        chk("grant_rd", 32'(host_rd), 32'(!exp_wr));
        host_ack = 1'b1;
        settle();
        chk("grant_ack", 32'(drv_ack), 32'(4'b0001 << exp_sel));
        tick();
        chk("xfer_req_clr", 32'({host_rd, host_wr}), 32'(0));
        repeat (3) tick();
        chk("xfer_sel_hold", 32'(sel), 32'(exp_sel));
        host_ack = 1'b0;
        tick();
        chk("xfer_done_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        reset    = 1'b1;
        drv_rd   = '0;
        drv_wr   = '0;
        host_ack = 1'b0;
        for (int i = 0; i < int'(NDR); i++) begin
            drv_lba[i]      = 32'h0;
            drv_buff_din[i] = 8'(8'h10 * i);
        end
        tick();
        tick();
        reset = 1'b0;

        chk("rst_rd", 32'(host_rd), 32'(0));
        chk("rst_wr", 32'(host_wr), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack", 32'(drv_ack), 32'(0));
        chk("rst_lba", host_lba, 32'h0);
        chk("rst_sel", 32'(sel), 32'(0));

        // Single read from drive 0
        drv_lba[0] = 32'h0000_0123;
        drv_rd[0]  = 1'b1;
        tick();
        chk("t1_rd", 32'(host_rd), 32'(1));
        chk("t1_lba", host_lba, 32'h123);
        chk("t1_sel", 32'(sel), 32'(0));
        chk("t1_busy", 32'(busy), 32'(1));
        chk("t1_noack", 32'(drv_ack), 32'(0));
        tick();
        tick();
        chk("t1_rd_held", 32'(host_rd), 32'(1));
        host_ack = 1'b1;
        settle();
        chk("t1_ack0", 32'(drv_ack), 32'(4'b0001));
        tick();
        drv_rd[0] = 1'b0;
        chk("t1_rd_clr", 32'(host_rd), 32'(0));
        for (int c = 0; c < 511; c++) begin
            chk("t1_ack_mirror", 32'(drv_ack), 32'(4'b0001));
            tick();
        end
        host_ack = 1'b0;
        settle();
        chk("t1_ack_fall", 32'(drv_ack), 32'(0));
        chk("t1_busy_xfer", 32'(busy), 32'(1));
        tick();
        chk("t1_busy_low", 32'(busy), 32'(0));
        chk("t1_lba_stable", host_lba, 32'h123);

        // All drives request continuously; last grant was 0 so rotation starts at 1
        for (int i = 0; i < int'(NDR); i++) drv_lba[i] = 32'h100 + 32'(i);
        drv_rd = 4'b1111;
        serve(2'd1, 32'h101, 1'b0);
        serve(2'd2, 32'h102, 1'b0);
        serve(2'd3, 32'h103, 1'b0);
        serve(2'd0, 32'h100, 1'b0);
        serve(2'd1, 32'h101, 1'b0);
        drv_rd = '0;

        // Drive 1 with both rd and wr: write wins, data muxed from drive 1
        tick();
        drv_lba[1] = 32'h55;
        drv_rd[1]  = 1'b1;
        drv_wr[1]  = 1'b1;
        tick();
        chk("t3_wr", 32'(host_wr), 32'(1));
        chk("t3_rd", 32'(host_rd), 32'(0));
        chk("t3_lba", host_lba, 32'h55);
        chk("t3_sel", 32'(sel), 32'(1));
        host_ack = 1'b1;
        tick();
        drv_rd[1] = 1'b0;
        drv_wr[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drv_buff_din[1] = 8'(8'hA0 + c);
            drv_buff_din[0] = 8'(8'h5A + c);
            settle();
            chk("t3_din", 32'(host_buff_din), 32'(8'hA0 + c));
            chk("t3_ack1", 32'(drv_ack), 32'(4'b0010));
            tick();
        end
        host_ack = 1'b0;
        tick();
        chk("t3_idle", 32'(busy), 32'(0));

        // Withdrawal in REQ then orphaned ack goes through DRAIN
        drv_lba[0] = 32'h77;
        drv_rd[0]  = 1'b1;
        tick();
        chk("t4_rd", 32'(host_rd), 32'(1));
        chk("t4_sel", 32'(sel), 32'(0));
        drv_rd[0] = 1'b0;
        tick();
        chk("t4_rd_clr", 32'(host_rd), 32'(0));
        chk("t4_idle", 32'(busy), 32'(0));
        tick();
        host_ack = 1'b1;
        settle();
        chk("t4_ack_idle", 32'(drv_ack), 32'(0));
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t4_drain_busy", 32'(busy), 32'(1));
            chk("t4_drain_ack", 32'(drv_ack), 32'(0));
        end
        host_ack = 1'b0;
        tick();
        chk("t4_drain_exit", 32'(busy), 32'(0));

        // Reset during XFER with host_ack still high
        drv_lba[2] = 32'h222;
        drv_rd[2]  = 1'b1;
        tick();
        chk("t5_sel", 32'(sel), 32'(2));
        chk("t5_lba", host_lba, 32'h222);
        host_ack = 1'b1;
        tick();
        chk("t5_ack2", 32'(drv_ack), 32'(4'b0100));
        reset     = 1'b1;
        drv_rd[2] = 1'b0;
        drv_lba[0] = 32'h3A0;
        drv_rd[0]  = 1'b1;
        drv_rd[3]  = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_rd", 32'(host_rd), 32'(0));
        chk("t5_rst_wr", 32'(host_wr), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_ack", 32'(drv_ack), 32'(0));
        chk("t5_rst_lba", host_lba, 32'h0);
        chk("t5_rst_sel", 32'(sel), 32'(0));
        tick();
        chk("t5_drain_busy", 32'(busy), 32'(1));
        chk("t5_drain_norq", 32'(host_rd), 32'(0));
        tick();
        tick();
        chk("t5_drain_hold", 32'(busy), 32'(1));
        chk("t5_drain_ack", 32'(drv_ack), 32'(0));
        host_ack = 1'b0;
        tick();
        chk("t5_idle", 32'(busy), 32'(0));
        tick();
        chk("t5_next_sel", 32'(sel), 32'(0));
        chk("t5_next_lba", host_lba, 32'h3A0);
        chk("t5_next_rd", 32'(host_rd), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c1581_sd_arb.md
# c1581_sd_arb

Host-side block-device arbiter placed between the per-drive SD ports of the multi-drive 1581 wrapper and the single HPS block-device port. It accepts independent sector read/write requests from up to four drives, grants one at a time in round-robin order, forwards the granted drive's LBA and request to the host, and routes the host's acknowledge and data-in mux back to that drive. Runs entirely in the `clk_sys` domain.

## Interface
Parameters:
- `NDR`, default 2: number of drive ports, legal range 1..4; `N = NDR-1`.

Ports:
- `clk_sys`  in  1  system clock. Single clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `drv_lba[NDR]`  in  32 each  per-drive sector LBA.
- `drv_rd`  in  N+1  per-drive read request, level, held until acked.
- `drv_wr`  in  N+1  per-drive write request, level, held until acked.
- `drv_ack`  out  N+1  per-drive acknowledge. Only the granted bit can be high.
- `drv_buff_din[NDR]`  in  8 each  per-drive write data toward the host.
- `host_lba`  out  32  LBA of the granted request.
- `host_rd`  out  1  read request to host.
- `host_wr`  out  1  write request to host.
- `host_ack`  in  1  host acknowledge. High for the whole 512-byte transfer.
- `host_buff_din`  out  8  selected drive's write data.
- `sel`  out  2  index of the granted or last-granted drive.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States:
- **IDLE**
  - Form the request vector `req[i] = drv_rd[i] | drv_wr[i]`.
  - Search `req` round-robin starting at `(last+1) mod NDR`, wrapping.
  - On the first hit `k`:
    - `sel <= k`, `last <= k`.
    - `host_lba <= drv_lba[k]`.
    - If `drv_wr[k]`: `host_wr <= 1`. Otherwise `host_rd <= 1`. Write wins when both are set.
    - Go to REQ.
  - If `host_ack` is high while in IDLE, go to DRAIN instead. The search is suppressed that cycle.
- **REQ**
  - If `host_ack` = 1: clear `host_rd`/`host_wr` and go to XFER.
  - Otherwise, if the granted drive drops both rd and wr (withdrawal, e.g. drive reset): clear `host_rd`/`host_wr` and go to IDLE.
  - If `host_ack` rises in the same cycle as the withdrawal, the ack takes priority and the block goes to XFER.
- **XFER**
  - Hold `sel` and `host_lba` stable.
  - Go to IDLE when `host_ack` = 0.
- **DRAIN**
  - Handles an orphaned acknowledge, i.e. one arriving after a withdrawal.
  - `drv_ack` is all zero.
  - Go to IDLE when `host_ack` = 0.

Routing:
- `drv_ack[i] = host_ack & (state ∈ {REQ, XFER}) & (sel == i)`. Combinational from `host_ack`; `sel` and state are registered.
- `host_buff_din = drv_buff_din[sel]`. Combinational mux, so it aligns with the host's registered buffer address.

Other rules:
- `last` resets to `NDR-1`, so drive 0 has first priority after reset.
- Request bits from drives not currently granted are ignored until the block returns to IDLE.
- With NDR=1, the search is trivial and `sel` stays 0.
- `sel` upper bits are 0 for indices ≥ NDR. Requests can never select a nonexistent port.

## Timing
Reset values:
- `host_rd`, `host_wr`, `busy`, `drv_ack`: 0.
- `host_lba`: 0; `sel`: 0.
- state: IDLE; `last`: NDR-1.
- Reset asserted mid-transfer: all outputs return to reset values on the next edge. A still-high `host_ack` afterwards sends the block to DRAIN.

Latency and handshake:
- Request sampled in IDLE at edge t → `host_rd`/`host_wr`/`host_lba` valid after edge t. `busy` goes high at the same edge.
- `host_ack` rise sampled at edge a → `host_rd`/`host_wr` low after edge a.
- `drv_ack` follows `host_ack` with zero cycles delay.
- `host_ack` fall sampled at edge f → IDLE after edge f. The earliest next grant is at edge f+1, so there is at least one idle cycle between transfers.
- `host_lba` is stable from grant until IDLE is re-entered.

## Test plan
1. NDR=2; drive 0 `drv_rd`, LBA 0x0000_0123; host acks 3 cycles later for 512 cycles.
   - `host_rd` high the cycle after the request, `host_lba`=0x123, `sel`=0.
   - `drv_ack[0]` mirrors `host_ack`; `drv_ack[1]`=0.
   - `busy` low one cycle after ack falls.
2. NDR=4; all four drives request continuously.
   - Grants go in order 0,1,2,3,0, each a complete ack cycle.
   - No drive is granted twice before the others are served.
3. Drive 1 asserts both rd and wr, LBA 0x55.
   - `host_wr`=1, `host_rd`=0, `host_lba`=0x55.
   - `host_buff_din` equals `drv_buff_din[1]` on every cycle of the ack.
4. Drive 0 requests, then drops rd in REQ before any ack.
   - Host request clears, state returns to IDLE.
   - A later 10-cycle `host_ack` pulse goes through DRAIN; no `drv_ack` bit rises; `busy`=1 during the pulse.
5. Assert `reset` for 1 cycle during XFER while `host_ack`=1.
   - All outputs are 0 after the edge.
   - State is DRAIN until `host_ack` falls; the next grant goes to drive 0.
